piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and sets the parallel word width in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST SHALL default to 1; 1 shifts din[WIDTH-1] out first, 0 shifts din[0] out first.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide; reset is asynchronous and active-low.
REQ-005 Port din SHALL be an input, WIDTH bits wide, carrying the parallel word to serialize.
REQ-006 Port load_valid SHALL be an input, 1 bit wide; high means din holds a word to accept.
REQ-007 Port load_ready SHALL be an output, 1 bit wide; high means the block accepts din this cycle.
REQ-008 Port so SHALL be an output, 1 bit wide, carrying the serial data bit that feeds the downstream SIPO si input.
REQ-009 Port so_valid SHALL be an output, 1 bit wide; high means so carries a live bit this cycle.
REQ-010 Port word_first SHALL be an output, 1 bit wide; high on the first bit of each word (frame alignment for the downstream SIPO).
REQ-011 Port word_last SHALL be an output, 1 bit wide; high on the last bit of each word.

Function
REQ-012 Internal state SHALL be: a one-entry holding register (hold_q, hold_full), a WIDTH-bit shift register, a bit counter cnt (0..WIDTH-1), and an FSM with states IDLE and SHIFT.
REQ-013 load_ready SHALL equal !hold_full (combinational); a transfer occurs when load_valid && load_ready at a rising edge, capturing din into hold_q and setting hold_full.
REQ-014 In IDLE with hold_full=1 at an edge: shift register <= hold_q, hold_full <= 0, cnt <= 0, state <= SHIFT.
REQ-015 In SHIFT, so_valid SHALL be 1, so SHALL be the current output-end bit of the shift register, word_first SHALL be (cnt==0), and word_last SHALL be (cnt==WIDTH-1).
REQ-016 In SHIFT with cnt<WIDTH-1, each edge SHALL shift one position toward the output end and increment cnt.
REQ-017 In SHIFT with cnt==WIDTH-1: if hold_full, reload from hold_q, clear hold_full, set cnt <= 0, and stay in SHIFT (gapless); otherwise go to IDLE.
REQ-018 Latency SHALL be: word accepted at edge N -> first bit valid on so after edge N+1 when the block is idle.
REQ-019 Throughput SHALL be: a word accepted any time before the final bit of the current word is streamed with zero idle cycles between words.
REQ-020 When so_valid=0, outputs so, word_first and word_last SHALL all be 0.
REQ-021 Acceptance into hold and reload from hold SHALL never occur on the same edge, because load_ready is low whenever hold_full is high.
REQ-022 load_valid while load_ready=0 SHALL be ignored, with din not sampled; the upstream holds din and load_valid until accepted.

Reset
REQ-023 rst_n low SHALL immediately clear state to IDLE, hold_full, cnt and the shift register to 0, and hold_q to 0.
REQ-024 During and after reset, outputs SHALL be: load_ready=1, so=0, so_valid=0, word_first=0, word_last=0.
REQ-025 Reset asserted mid-word SHALL discard both the partial word and any held word; no further bits are emitted.

Structure
REQ-026 A shared package/include piso_pkg SHALL hold the FSM state encodings (IDLE=0, SHIFT=1) and the default WIDTH constant.
REQ-027 One sub-module, piso_bitcnt (a modulo-WIDTH counter with clear, enable and terminal-count output), SHALL implement cnt; all other logic stays in piso_serializer.

Verification
REQ-028 Scenario: reset, then load 4'b1001 once -> so = 1,0,0,1 on four consecutive cycles, word_first on cycle 1, word_last on cycle 4, then so_valid=0.
REQ-029 Scenario: 4'b1001 then 4'b0110 presented back-to-back -> second word accepted while first shifts; eight consecutive valid bits 1,0,0,1,0,1,1,0 with no gap.
REQ-030 Scenario: load_valid held high with three words -> load_ready low while hold is full; all three words are emitted in order with no loss or duplication.
REQ-031 Scenario: rst_n pulsed low after bit 2 of 4'b1010 with a second word held -> so_valid=0 and load_ready=1 immediately; no further bits appear.
REQ-032 Scenario: MSB_FIRST=0 with load 4'b0001 -> so = 1,0,0,0.
REQ-033 Scenario: loopback so into a downstream 4-bit SIPO clocked on clk; load 4'b1001 -> the SIPO q equals 4'b1001 on the cycle after word_last.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
package piso_pkg;

    // FSM encoding: IDLE = 0, SHIFT = 1
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default parallel word width
    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_bitcnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal-count flag.
module piso_bitcnt
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Terminal count flags the last bit position of a word
    always_comb begin
        tc = (cnt == LAST);
    end

    // Count bit positions, wrapping to zero after the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word holding register so that
// consecutive words stream out with no idle cycles between them.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             word_first,
    output logic             word_last
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             reload;
    logic             shift;
    logic             accept;
    logic             out_bit;

    piso_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .tc   (cnt_tc)
    );

    // Handshake and output-end bit selection
    always_comb begin
        load_ready = !hold_full;
        accept     = load_valid && load_ready;
        out_bit    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    end

    // Next-state, datapath controls and serial outputs
    always_comb begin
        state_d    = state_q;
        reload     = 1'b0;
        shift      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        so_valid   = 1'b0;
        so         = 1'b0;
        word_first = 1'b0;
        word_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    reload  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                so_valid   = 1'b1;
                so         = out_bit;
                word_first = (cnt == '0);
                word_last  = cnt_tc;
                if (!cnt_tc) begin
                    shift  = 1'b1;
                    cnt_en = 1'b1;
                end else if (hold_full) begin
                    // Back-to-back reload keeps the stream gapless
                    reload  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register: filled on accept, emptied on reload (never both at once)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (reload) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_q    <= din;
            hold_full <= 1'b1;
        end
    end

    // Shift register moves one position toward the output end per bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (reload) begin
            sreg <= hold_q;
        end else if (shift) begin
            sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: an MSB-first and an LSB-first
// instance share the same stimulus and are compared against a schedule model.
module tb_piso_serializer;

    localparam int W = 4;
    localparam logic [9:0] IDLE_V = 10'b10000_10000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;

    logic rdy_m, so_m, sv_m, wf_m, wl_m;
    logic rdy_l, so_l, sv_l, wf_l, wl_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .so(so_m), .so_valid(sv_m),
        .word_first(wf_m), .word_last(wl_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .so(so_l), .so_valid(sv_l),
        .word_first(wf_l), .word_last(wl_l)
    );

    // Downstream SIPO fed by the MSB-first serial stream
    logic [W-1:0] sipo_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sipo_q <= '0;
        else if (sv_m) sipo_q <= {sipo_q[W-2:0], so_m};
    end

    logic [9:0] act_v;
    assign act_v = {rdy_m, sv_m, so_m, wf_m, wl_m, rdy_l, sv_l, so_l, wf_l, wl_l};

    // Reference model: each accepted word gets a start cycle; bit i of a word
    // is on the wire during cycle start+i, and the word waits in the holding
    // slot from its accept cycle until its start cycle.
    typedef struct {
        logic [W-1:0] data;
        int           acc;
        int           start;
    } sched_t;

    sched_t     sched[$];
    int         k;
    int         last_end;
    logic       exp_ready;
    logic [9:0] exp_v;
    bit         accepted;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [9:0] model_outputs();
        logic       hold;
        logic [4:0] m;
        logic [4:0] l;
        hold = 1'b0;
        m = '0;
        l = '0;
        foreach (sched[i]) begin
            int b;
            b = k - sched[i].start;
            if (sched[i].acc <= k && k < sched[i].start) hold = 1'b1;
            if (b >= 0 && b < W) begin
                m = {1'b0, 1'b1, sched[i].data[W-1-b], b == 0, b == W-1};
                l = {1'b0, 1'b1, sched[i].data[b],     b == 0, b == W-1};
            end
        end
        m[4] = !hold;
        l[4] = !hold;
        return {m, l};
    endfunction

    task automatic model_reset();
        sched.delete();
        k         = 0;
        last_end  = -10;
        exp_ready = 1'b1;
        exp_v     = IDLE_V;
    endtask

    // Advance one clock, update the model, and sample #1 after the edge
    task automatic step();
        @(posedge clk);
        k++;
        accepted = load_valid && exp_ready;
        if (accepted) begin
            int s;
            s = (k + 1 > last_end + 1) ? k + 1 : last_end + 1;
            sched.push_back('{din, k, s});
            last_end = s + W - 1;
        end
        while (sched.size() > 0 && sched[0].start + W - 1 < k - 1) void'(sched.pop_front());
        #1;
        exp_v     = model_outputs();
        exp_ready = exp_v[9];
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_valid = 1'b0;
        #2;
        checks++;
        if (act_v !== IDLE_V) begin
            errors++;
            $display("FAIL reset_outputs act=%b exp=%b", act_v, IDLE_V);
        end
        release_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d act=%b exp=%b", k, act_v, exp_v);
            end
        end
    endtask

    // Single 1001 (both orders), then 0001; SIPO loopback checked after word_last
    task automatic test_single();
        int a;
        din = 4'b1001;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        a = k;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL single_1001 cyc=%0d act=%b exp=%b", k - a, act_v, exp_v);
            end
            if (k == a + W + 1) begin
                checks++;
                if (sipo_q !== 4'b1001) begin
                    errors++;
                    $display("FAIL sipo_loopback act=%b exp=%b", sipo_q, 4'b1001);
                end
            end
        end
        din = 4'b0001;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL single_0001 cyc=%0d act=%b exp=%b", c, act_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2];
        logic [7:0]   stream;
        int           idx, nbits, first_c, last_c;
        words[0] = 4'b1001;
        words[1] = 4'b0110;
        stream = '0;
        idx = 0; nbits = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 14; c++) begin
            load_valid = (idx < 2);
            din = words[idx < 2 ? idx : 1];
            step();
            if (accepted) idx++;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc=%0d act=%b exp=%b", c, act_v, exp_v);
            end
            if (sv_m) begin
                stream = {stream[6:0], so_m};
                nbits++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        load_valid = 1'b0;
        checks++;
        if (stream !== 8'b1001_0110 || nbits != 8 || last_c - first_c != 7) begin
            errors++;
            $display("FAIL b2b_stream act=%b bits=%0d span=%0d exp=10010110 bits=8 span=8",
                     stream, nbits, last_c - first_c + 1);
        end
    endtask

    task automatic test_hold_full();
        logic [W-1:0] words[3];
        logic [3*W-1:0] stream;
        logic [3*W-1:0] want;
        int idx, nbits;
        for (int i = 0; i < 3; i++) words[i] = W'($urandom_range(0, (1 << W) - 1));
        want = {words[0], words[1], words[2]};
        stream = '0;
        idx = 0; nbits = 0;
        for (int c = 0; c < 20; c++) begin
            load_valid = (idx < 3);
            din = words[idx < 3 ? idx : 2];
            step();
            if (accepted) idx++;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL hold_full cyc=%0d act=%b exp=%b", c, act_v, exp_v);
            end
            if (sv_m) begin
                stream = {stream[3*W-2:0], so_m};
                nbits++;
            end
        end
        load_valid = 1'b0;
        checks++;
        if (stream !== want || nbits != 3 * W) begin
            errors++;
            $display("FAIL hold_full_stream act=%h bits=%0d exp=%h bits=%0d", stream, nbits, want, 3 * W);
        end
    endtask

    task automatic test_reset_midword();
        int nbits, seen;
        logic [W-1:0] words[2];
        int idx;
        words[0] = 4'b1010;
        words[1] = 4'b0111;
        idx = 0; nbits = 0; seen = 0;
        for (int c = 0; c < 12 && nbits < 2; c++) begin
            load_valid = (idx < 2);
            din = words[idx < 2 ? idx : 1];
            step();
            if (accepted) idx++;
            if (sv_m) nbits++;
        end
        load_valid = 1'b0;
        checks++;
        if (nbits != 2 || idx != 2) begin
            errors++;
            $display("FAIL midword_setup bits=%0d words=%0d exp bits=2 words=2", nbits, idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_v !== IDLE_V) begin
            errors++;
            $display("FAIL midword_reset act=%b exp=%b", act_v, IDLE_V);
        end
        release_reset();
        for (int c = 0; c < 8; c++) begin
            step();
            if (sv_m || sv_l) seen++;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL after_reset cyc=%0d act=%b exp=%b", c, act_v, exp_v);
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_bits_after_reset act=%0d exp=0", seen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!load_valid && $urandom_range(0, 2) != 0) begin
                din = W'($urandom_range(0, (1 << W) - 1));
                load_valid = 1'b1;
            end
            step();
            if (accepted) load_valid = 1'b0;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d act=%b exp=%b", c, act_v, exp_v);
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
